// File: rtl/sevseg_pkg.sv
// Shared 7-segment definitions: active-low {g,f,e,d,c,b,a} patterns, scan FSM states, BCD helper.
// Used by both the display encoder and the scan-bus decoder.
package sevseg_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } scan_state_t;

   // Hex digits can exceed 9, so the result saturates at the two-digit maximum.
   function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] ones, input logic [3:0] tens);
      logic [7:0] sum;
      sum = 8'(ones) + 8'(tens) * 8'd10;
      return (sum > 8'd99) ? 7'd99 : sum[6:0];
   endfunction

endpackage

// File: rtl/sevseg_scan_decoder_if.sv
// Scan bus plus recovered-frame outputs of the 7-segment scan decoder.
// SEVSEG_HEX_DECODE_EN adds the per-slot decimal-point mask.
interface sevseg_scan_decoder_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [NUM_DIGITS-1:0]   anode;
   logic [7:0]              cathode;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [6:0]              value;
   logic                    frame_valid;
   logic                    digits_valid;
   logic                    seg_err;
   logic                    multi_anode_err;
`ifdef SEVSEG_HEX_DECODE_EN
   logic [NUM_DIGITS-1:0]   dp_mask;
`endif

   modport master (
      output anode, cathode,
`ifdef SEVSEG_HEX_DECODE_EN
      input  dp_mask,
`endif
      input  digits, value, frame_valid, digits_valid, seg_err, multi_anode_err
   );

   modport slave (
      input  anode, cathode,
`ifdef SEVSEG_HEX_DECODE_EN
      output dp_mask,
`endif
      output digits, value, frame_valid, digits_valid, seg_err, multi_anode_err
   );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Combinational active-low 7-segment pattern to BCD/hex nibble decoder.
// SEVSEG_HEX_DECODE_EN accepts A,b,C,d,E,F; otherwise only 0-9 and blank decode.
module seg7_pattern_decoder
   import sevseg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       valid
);

   always_comb begin
      nibble = '0;
      valid  = 1'b1;
      case (pattern)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_BLANK: nibble = 4'h0;
`ifdef SEVSEG_HEX_DECODE_EN
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
`endif
         default:   valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: debounces each scan slot, decodes it and publishes frames.
// SEVSEG_HEX_DECODE_EN enables hex digit decode and the per-slot dp_mask output.
module sevseg_scan_decoder
   import sevseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input logic                   clk,
   input logic                   rst_n,
   sevseg_scan_decoder_if.slave  bus
);

   localparam int unsigned SW    = NUM_DIGITS + 8;
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned SC_W  = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned IC_W  = $clog2(TIMEOUT_CYCLES + 1);

   logic [SW-1:0]         sync1, sync2, prev;
   logic                  multi_q;
   scan_state_t           state;
   logic [SC_W-1:0]       stable_cnt;
   logic [IC_W-1:0]       idle_cnt;
   logic [3:0]            slots [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] mask;
`ifdef SEVSEG_HEX_DECODE_EN
   logic [NUM_DIGITS-1:0] slot_dp;
`endif

   logic [NUM_DIGITS-1:0] anode_s;
   logic [IDX_W:0]        low_cnt;
   logic [IDX_W-1:0]      slot_idx;
   logic                  none_low, one_low, multi, changed, accept, lost;
   logic [3:0]            dec_nibble;
   logic                  dec_valid;

   assign anode_s = sync2[SW-1:8];

   always_comb begin
      low_cnt  = '0;
      slot_idx = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (!anode_s[i]) begin
            low_cnt  = low_cnt + (IDX_W+1)'(1);
            slot_idx = IDX_W'(i);
         end
      end
   end

   assign none_low = (low_cnt == '0);
   assign one_low  = (low_cnt == (IDX_W+1)'(1));
   assign multi    = !none_low && !one_low;
   assign changed  = (sync2 != prev);
   assign accept   = (state == S_SETTLE) && one_low && !changed &&
                     (stable_cnt == SC_W'(STABLE_CYCLES - 1));
   assign lost     = (idle_cnt == IC_W'(TIMEOUT_CYCLES));

   seg7_pattern_decoder u_dec (
      .pattern (sync2[6:0]),
      .nibble  (dec_nibble),
      .valid   (dec_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1                <= '1;
         sync2                <= '1;
         prev                 <= '1;
         multi_q              <= 1'b0;
         state                <= S_IDLE;
         stable_cnt           <= '0;
         idle_cnt             <= '0;
         mask                 <= '0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
         bus.digits           <= '0;
         bus.value            <= '0;
         bus.frame_valid      <= 1'b0;
         bus.digits_valid     <= 1'b0;
         bus.seg_err          <= 1'b0;
         bus.multi_anode_err  <= 1'b0;
`ifdef SEVSEG_HEX_DECODE_EN
         slot_dp              <= '0;
         bus.dp_mask          <= '0;
`endif
      end else begin
         sync1               <= {bus.anode, bus.cathode};
         sync2               <= sync1;
         prev                <= sync2;
         multi_q             <= multi;
         bus.frame_valid     <= 1'b0;
         bus.seg_err         <= 1'b0;
         bus.multi_anode_err <= multi && !multi_q;

         if (&mask) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) bus.digits[4*i +: 4] <= slots[i];
            bus.value        <= bcd_pair_to_bin(slots[0], slots[1]);
            bus.frame_valid  <= 1'b1;
            bus.digits_valid <= 1'b1;
            mask             <= '0;
`ifdef SEVSEG_HEX_DECODE_EN
            bus.dp_mask      <= slot_dp;
`endif
         end
         if (lost) begin
            bus.digits_valid <= 1'b0;
            mask             <= '0;
         end

         if (accept)     idle_cnt <= '0;
         else if (!lost) idle_cnt <= idle_cnt + IC_W'(1);

         // Mask bit set below is issued after the clears above, so an accept never gets lost.
         case (state)
            S_IDLE: begin
               stable_cnt <= '0;
               if (!none_low) state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (none_low) begin
                  state      <= S_IDLE;
                  stable_cnt <= '0;
               end else if (changed || multi) begin
                  stable_cnt <= '0;
               end else if (accept) begin
                  state      <= S_HOLD;
                  stable_cnt <= '0;
                  if (dec_valid) begin
                     slots[slot_idx] <= dec_nibble;
                     mask[slot_idx]  <= 1'b1;
`ifdef SEVSEG_HEX_DECODE_EN
                     slot_dp[slot_idx] <= ~sync2[7];
`endif
                  end else begin
                     bus.seg_err <= 1'b1;
                  end
               end else begin
                  stable_cnt <= stable_cnt + SC_W'(1);
               end
            end
            S_HOLD: begin
               stable_cnt <= '0;
               if (changed) state <= none_low ? S_IDLE : S_SETTLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
